// File: rtl/skinny_iter_core.sv
// Iterative SKINNY-128-384 encryption core: NUMRND rounds per clock, self-generated
// round constants, valid/ready load and result handshakes.
module skinny_iter_core #(
  parameter int unsigned NUMRND  = 2,
  parameter int unsigned TOTRND  = 40,
  parameter int unsigned FULLCNT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [127:0]              pt,
  input  logic [64+64*FULLCNT-1:0]  cnt,
  input  logic [127:0]              tweak,
  input  logic [127:0]              key,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [127:0]              ct,
  output logic                      busy
);

  localparam int unsigned CW = 64 + 64 * FULLCNT;
  localparam int unsigned RW = $clog2(TOTRND + 1);

  // Cell 0 sits in the most significant byte, matching the row-major port layout.
  typedef logic [0:15][7:0] cells_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  cells_t        st_q, tk1_q, tk2_q, tk3_q, ct_q;
  logic [5:0]    rc_q;
  logic [RW-1:0] rcnt_q;

  cells_t        st_n, tk1_n, tk2_n, tk3_n;
  logic [5:0]    rc_n;
  logic [127:0]  tk1_load;
  logic          load, step, last;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    y = x;
    for (int unsigned i = 0; i < 3; i++) begin
      y[4] = y[4] ^ ~(y[7] | y[6]);
      y[0] = y[0] ^ ~(y[3] | y[2]);
      y    = {y[2], y[1], y[7], y[6], y[4], y[0], y[3], y[5]};
    end
    y[4] = y[4] ^ ~(y[7] | y[6]);
    y[0] = y[0] ^ ~(y[3] | y[2]);
    return {y[7:3], y[1], y[2], y[0]};
  endfunction

  function automatic cells_t tk_perm(input cells_t t);
    return {t[9], t[15], t[8], t[13], t[10], t[14], t[12], t[11],
            t[0], t[1],  t[2], t[3],  t[4],  t[5],  t[6],  t[7]};
  endfunction

  function automatic cells_t tk2_lfsr(input cells_t t);
    cells_t o;
    o = t;
    for (int unsigned i = 0; i < 8; i++) o[i] = {t[i][6:0], t[i][7] ^ t[i][5]};
    return o;
  endfunction

  function automatic cells_t tk3_lfsr(input cells_t t);
    cells_t o;
    o = t;
    for (int unsigned i = 0; i < 8; i++) o[i] = {t[i][0] ^ t[i][6], t[i][7:1]};
    return o;
  endfunction

  function automatic cells_t skinny_round(input cells_t s, input cells_t rtk,
                                          input logic [5:0] rc);
    cells_t a, b, o;
    for (int unsigned i = 0; i < 16; i++) a[i] = sbox(s[i]);
    a[0] = a[0] ^ {4'h0, rc[3:0]};
    a[4] = a[4] ^ {6'h00, rc[5:4]};
    a[8] = a[8] ^ 8'h02;
    for (int unsigned i = 0; i < 8; i++) a[i] = a[i] ^ rtk[i];
    for (int unsigned r = 0; r < 4; r++) begin
      for (int unsigned c = 0; c < 4; c++) begin
        b[4*r + c] = a[4*r + ((c + 4 - r) % 4)];
      end
    end
    for (int unsigned c = 0; c < 4; c++) begin
      o[c + 4]  = b[c];
      o[c + 8]  = b[c + 4] ^ b[c + 8];
      o[c + 12] = b[c] ^ b[c + 8];
      o[c]      = b[c + 12] ^ o[c + 12];
    end
    return o;
  endfunction

  // A 64-bit counter occupies the upper half of TK1; the lower half stays zero.
  assign tk1_load = 128'(cnt) << (128 - CW);

  always_comb begin
    st_n  = st_q;
    tk1_n = tk1_q;
    tk2_n = tk2_q;
    tk3_n = tk3_q;
    rc_n  = rc_q;
    for (int unsigned i = 0; i < NUMRND; i++) begin
      rc_n  = {rc_n[4:0], rc_n[5] ^ rc_n[4] ^ 1'b1};
      st_n  = skinny_round(st_n, tk1_n ^ tk2_n ^ tk3_n, rc_n);
      tk1_n = tk_perm(tk1_n);
      tk2_n = tk2_lfsr(tk_perm(tk2_n));
      tk3_n = tk3_lfsr(tk_perm(tk3_n));
    end
  end

  assign last = (32'(rcnt_q) + NUMRND) == TOTRND;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            load    = 1'b1;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= '0;
      tk1_q  <= '0;
      tk2_q  <= '0;
      tk3_q  <= '0;
      rc_q   <= '0;
      rcnt_q <= '0;
      ct_q   <= '0;
    end else if (load) begin
      st_q   <= pt;
      tk1_q  <= tk1_load;
      tk2_q  <= tweak;
      tk3_q  <= key;
      rc_q   <= '0;
      rcnt_q <= '0;
    end else if (step) begin
      st_q   <= st_n;
      tk1_q  <= tk1_n;
      tk2_q  <= tk2_n;
      tk3_q  <= tk3_n;
      rc_q   <= rc_n;
      rcnt_q <= rcnt_q + RW'(NUMRND);
      if (last) ct_q <= st_n;
    end
  end

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign ct        = ct_q;

endmodule

// File: tb/tb_skinny_iter_core.sv
// Self-checking bench for skinny_iter_core: table-driven SKINNY reference model,
// per-cycle handshake/ct comparison on the default core plus directed variants.
module tb_skinny_iter_core;

  localparam int unsigned TOT = 40;
  localparam int unsigned NUM = 2;
  localparam int unsigned LAT = TOT / NUM;

  localparam logic [127:0] V_TK1 = 128'hdf889548cfc7ea52d296339301797449;
  localparam logic [127:0] V_TK2 = 128'hab588a34a47f1ab2dfe9c8293fbea9a5;
  localparam logic [127:0] V_TK3 = 128'hab1afac2611012cd8cef952618c3ebe8;
  localparam logic [127:0] V_PT  = 128'ha3994b66ad85a3459f44e92b08f550cb;
  localparam logic [127:0] V_CT  = 128'h94ecf589e2017c601b38c6346a10dcfa;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [127:0] pt, tk1, tweak, key;
  logic [63:0]  cnt_s;

  logic a_iv = 1'b0, a_or = 1'b1, a_ir, a_ov, a_busy;
  logic b_iv = 1'b0, b_or = 1'b1, b_ir, b_ov, b_busy;
  logic c_iv = 1'b0, c_or = 1'b1, c_ir, c_ov, c_busy;
  logic [127:0] a_ct, b_ct, c_ct;

  skinny_iter_core #(.NUMRND(NUM), .TOTRND(TOT), .FULLCNT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .pt(pt), .cnt(tk1),
    .tweak(tweak), .key(key), .out_valid(a_ov), .out_ready(a_or), .ct(a_ct), .busy(a_busy));

  skinny_iter_core #(.NUMRND(7), .TOTRND(56), .FULLCNT(1)) dut56 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .pt(pt), .cnt(tk1),
    .tweak(tweak), .key(key), .out_valid(b_ov), .out_ready(b_or), .ct(b_ct), .busy(b_busy));

  skinny_iter_core #(.NUMRND(NUM), .TOTRND(TOT), .FULLCNT(0)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .pt(pt), .cnt(cnt_s),
    .tweak(tweak), .key(key), .out_valid(c_ov), .out_ready(c_or), .ct(c_ct), .busy(c_busy));

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_on = 1'b0;

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference tables straight from the cipher definition.
  int unsigned sr_tab [16] = '{0, 1, 2, 3, 7, 4, 5, 6, 10, 11, 8, 9, 13, 14, 15, 12};
  int unsigned pt_tab [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
  int unsigned sb_src [8]  = '{5, 3, 0, 4, 6, 7, 1, 2};
  int unsigned mc [4][4]   = '{'{1, 0, 1, 1}, '{1, 0, 0, 0}, '{0, 1, 1, 0}, '{1, 0, 1, 0}};

  function automatic int unsigned sbox_m(input int unsigned v);
    int unsigned x, y;
    x = v;
    for (int r = 0; r < 4; r++) begin
      x = x ^ (((~((x >> 7) | (x >> 6))) & 1) << 4) ^ ((~((x >> 3) | (x >> 2))) & 1);
      if (r < 3) begin
        y = 0;
        for (int b = 0; b < 8; b++) y = y | (((x >> sb_src[b]) & 1) << b);
        x = y;
      end else begin
        x = (x & 32'hF9) | ((x >> 1) & 2) | ((x << 1) & 4);
      end
    end
    return x & 32'hFF;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] p, input logic [127:0] k1,
                                             input logic [127:0] k2, input logic [127:0] k3,
                                             input int unsigned rounds);
    int unsigned s [16];
    int unsigned u [16];
    int unsigned t [3][16];
    int unsigned rc, acc;
    logic [127:0] o;
    rc = 0;
    for (int i = 0; i < 16; i++) begin
      s[i]    = int'(p[127-8*i -: 8]);
      t[0][i] = int'(k1[127-8*i -: 8]);
      t[1][i] = int'(k2[127-8*i -: 8]);
      t[2][i] = int'(k3[127-8*i -: 8]);
    end
    for (int unsigned r = 0; r < rounds; r++) begin
      rc = ((rc << 1) & 63) | ((((rc >> 5) ^ (rc >> 4)) & 1) ^ 1);
      for (int i = 0; i < 16; i++) s[i] = sbox_m(s[i]);
      s[0] = s[0] ^ (rc & 15);
      s[4] = s[4] ^ ((rc >> 4) & 3);
      s[8] = s[8] ^ 2;
      for (int i = 0; i < 8; i++) s[i] = s[i] ^ t[0][i] ^ t[1][i] ^ t[2][i];
      for (int i = 0; i < 16; i++) u[i] = s[sr_tab[i]];
      for (int c = 0; c < 4; c++) begin
        for (int rr = 0; rr < 4; rr++) begin
          acc = 0;
          for (int k = 0; k < 4; k++) if (mc[rr][k] != 0) acc = acc ^ u[4*k + c];
          s[4*rr + c] = acc;
        end
      end
      for (int j = 0; j < 3; j++) begin
        for (int i = 0; i < 16; i++) u[i] = t[j][pt_tab[i]];
        for (int i = 0; i < 16; i++) t[j][i] = u[i];
      end
      for (int i = 0; i < 8; i++) begin
        t[1][i] = ((t[1][i] << 1) & 255) | (((t[1][i] >> 7) ^ (t[1][i] >> 5)) & 1);
        t[2][i] = (t[2][i] >> 1) | (((t[2][i] ^ (t[2][i] >> 6)) & 1) << 7);
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = 8'(s[i]);
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Cycle-level expectation for the default core, driven only by its inputs.
  int unsigned  m_left = 0;
  logic         m_have = 1'b0;
  logic [127:0] m_ct = '0;
  logic [127:0] m_next = '0;

  initial begin
    logic acc;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_left = 0;
        m_have = 1'b0;
        m_ct   = '0;
      end else begin
        acc = a_iv && (m_left == 0) && (!m_have || a_or);
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_have = 1'b1;
            m_ct   = m_next;
          end
        end else if (m_have && a_or) begin
          m_have = 1'b0;
        end
        if (acc) begin
          m_next = model_enc(pt, tk1, tweak, key, TOT);
          m_left = LAT;
          m_have = 1'b0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_on) begin
        check("in_ready",  128'(a_ir),   128'((m_left == 0) && (!m_have || a_or)));
        check("out_valid", 128'(a_ov),   128'(m_have));
        check("busy",      128'(a_busy), 128'(m_left > 0));
        check("ct",        a_ct,         m_ct);
      end
    end
  end

  task automatic start(input int unsigned which);
    if (which == 0) a_iv = 1'b1;
    else if (which == 1) b_iv = 1'b1;
    else c_iv = 1'b1;
    @(posedge clk); #1;
    a_iv = 1'b0;
    b_iv = 1'b0;
    c_iv = 1'b0;
  endtask

  task automatic wait_valid(input int unsigned which, output int lat);
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if ((which == 0 && a_ov) || (which == 1 && b_ov) || (which == 2 && c_ov)) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    logic [127:0] exp_c;
    pt = '0; tk1 = '0; tweak = '0; key = '0; cnt_s = '0;

    #1;
    check("rst_in_ready",  128'(a_ir),   128'(1));
    check("rst_out_valid", 128'(a_ov),   128'(0));
    check("rst_busy",      128'(a_busy), 128'(0));
    check("rst_ct",        a_ct,         128'(0));
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_on = 1'b1;

    check("pin_sbox_00", 128'(sbox_m(0)), 128'(8'h65));
    check("pin_sbox_01", 128'(sbox_m(1)), 128'(8'h4c));
    check("pin_model_56", model_enc(V_PT, V_TK1, V_TK2, V_TK3, 56), V_CT);

    // Published 56-round vector at 7 rounds per clock.
    pt = V_PT; tk1 = V_TK1; tweak = V_TK2; key = V_TK3;
    check("b_in_ready", 128'(b_ir), 128'(1));
    start(1);
    wait_valid(1, lat);
    check("b_latency", 128'(lat), 128'(8));
    check("b_ct", b_ct, V_CT);
    @(posedge clk); #1;

    // 64-bit counter variant.
    cnt_s = 64'h0000000000000001; pt = rnd128(); tweak = rnd128(); key = rnd128();
    exp_c = model_enc(pt, 128'h0000000000000001_0000000000000000, tweak, key, TOT);
    start(2);
    wait_valid(2, lat);
    check("c_latency", 128'(lat), 128'(LAT));
    check("c_ct", c_ct, exp_c);
    @(posedge clk); #1;

    // Default core: vector, then a stalled consumer with a pending load.
    pt = V_PT; tk1 = V_TK1; tweak = V_TK2; key = V_TK3;
    a_or = 1'b0;
    start(0);
    wait_valid(0, lat);
    check("a_latency", 128'(lat), 128'(LAT));
    pt = rnd128(); tk1 = rnd128(); tweak = rnd128(); key = rnd128();
    a_iv = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      check("hold_in_ready",  128'(a_ir), 128'(0));
      check("hold_out_valid", 128'(a_ov), 128'(1));
    end

    // Back-to-back: consume and reload on the same edge.
    a_or = 1'b1;
    @(posedge clk); #1;
    a_iv = 1'b0;
    check("b2b_busy", 128'(a_busy), 128'(1));
    wait_valid(0, lat);
    check("b2b_latency", 128'(lat), 128'(LAT));
    @(posedge clk); #1;

    // Reset pulse in the middle of a run.
    pt = rnd128(); tk1 = rnd128(); tweak = rnd128(); key = rnd128();
    start(0);
    repeat (6) begin
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(a_ov),   128'(0));
    check("midrst_in_ready",  128'(a_ir),   128'(1));
    check("midrst_busy",      128'(a_busy), 128'(0));
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    pt = rnd128(); tk1 = rnd128(); tweak = rnd128(); key = rnd128();
    start(0);
    wait_valid(0, lat);
    check("post_rst_latency", 128'(lat), 128'(LAT));
    @(posedge clk); #1;

    // Random handshakes and data; the compare process checks every cycle.
    for (int i = 0; i < 1200; i++) begin
      a_iv  = ($urandom_range(0, 2) == 0);
      a_or  = ($urandom_range(0, 3) != 0);
      pt    = rnd128();
      tk1   = rnd128();
      tweak = rnd128();
      key   = rnd128();
      @(posedge clk); #1;
    end
    a_iv = 1'b0;
    a_or = 1'b1;
    repeat (LAT + 4) begin
      @(posedge clk); #1;
    end
    check("drain_idle", 128'({a_ir, a_ov, a_busy}), 128'(3'b100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
